// File: rtl/uart_loader_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the UART frame loader.
// Frame layout: START, addr[31:0] LE, data[31:0] LE, END.
package uart_loader_ctrl_pkg;

    localparam logic [7:0] START_BYTE     = 8'hAA;
    localparam logic [7:0] END_BYTE       = 8'h55;

    localparam logic [3:0] REG_DMEM_MAX   = 4'h3;
    localparam logic [3:0] REG_IMEM       = 4'h4;
    localparam logic [3:0] REG_CTRL       = 4'h5;

    localparam logic [1:0] CTRL_CPU_RESET = 2'd0;
    localparam logic [1:0] CTRL_RESUME    = 2'd1;
    localparam logic [1:0] CTRL_MASTER    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_TAIL  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_loader_ctrl_if.sv
// Byte-stream input and memory write port of the UART loader.
// master = loader side, slave = UART receiver / memory side.
interface uart_loader_ctrl_if #(
    parameter int WIDTH_D = 32,
    parameter int DEPTH_A = 12
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               wr_valid;
    logic               wr_ready;
    logic               wr_sel_i;
    logic [DEPTH_A-1:0] wr_addr;
    logic [WIDTH_D-1:0] wr_data;

    modport master (
        input  rx_data, rx_valid, wr_ready,
        output wr_valid, wr_sel_i, wr_addr, wr_data
    );

    modport slave (
        output rx_data, rx_valid, wr_ready,
        input  wr_valid, wr_sel_i, wr_addr, wr_data
    );
endinterface

// File: rtl/uart_loader_watchdog.sv
// Inter-byte gap watchdog: counts enabled idle cycles, expires after TIMEOUT.
module uart_loader_watchdog #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam logic [15:0] TC = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    assign o_expire = i_enable && !i_clear && (r_count == TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'd0;
        end else if (i_clear || o_expire) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end
endmodule

// File: rtl/uart_loader_ctrl.sv
// UART frame decoder: turns 10-byte frames into memory writes or loader
// control-register updates.
//
// state    | meaning
// IDLE     | waiting for START byte
// ADDR     | collecting 4 address bytes (LE)
// DATA     | collecting 4 data bytes (LE)
// TAIL     | expecting END byte, then decode region
// WRITE    | holding write request until wr_ready
module uart_loader_ctrl
    import uart_loader_ctrl_pkg::*;
#(
    parameter int          WIDTH_D        = 32,
    parameter int          DEPTH_A        = 12,
    parameter int unsigned TIMEOUT        = 50000,
    parameter logic        CPU_RESET_INIT = 1'b0,
    parameter logic        MASTER_INIT    = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    uart_loader_ctrl_if.master  if_ldr,
    output logic                o_cpu_reset,
    output logic                o_resume,
    output logic                o_master,
    output logic                o_busy,
    output logic [7:0]          o_err_count
);
    state_t             r_state, w_state_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    // Only addr[15:0] matters: bits above are never decoded.
    logic [15:0]        r_addr, w_addr_nxt;
    logic [31:0]        r_data, w_data_nxt;
    logic               r_wr_valid, w_wr_valid_nxt;
    logic               r_wr_sel_i, w_wr_sel_nxt;
    logic [DEPTH_A-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [WIDTH_D-1:0] r_wr_data, w_wr_data_nxt;
    logic               r_cpu_reset, w_cpu_reset_nxt;
    logic               r_resume, w_resume_nxt;
    logic               r_master, w_master_nxt;
    logic               r_busy;
    logic [7:0]         r_err_count;
    logic               w_err_evt;
    logic [3:0]         w_region;
    logic               w_wd_enable;
    logic               w_wd_expire;

    assign w_region    = r_addr[15:12];
    assign w_wd_enable = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_TAIL);

    uart_loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (if_ldr.rx_valid),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_wr_valid_nxt  = r_wr_valid;
        w_wr_sel_nxt    = r_wr_sel_i;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_cpu_reset_nxt = r_cpu_reset;
        w_resume_nxt    = r_resume;
        w_master_nxt    = r_master;
        w_err_evt       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (if_ldr.rx_valid && (if_ldr.rx_data == START_BYTE)) begin
                    w_state_nxt = ST_ADDR;
                    w_idx_nxt   = 2'd0;
                end
            end
            ST_ADDR: begin
                if (if_ldr.rx_valid) begin
                    if (r_idx == 2'd0) w_addr_nxt[7:0]  = if_ldr.rx_data;
                    if (r_idx == 2'd1) w_addr_nxt[15:8] = if_ldr.rx_data;
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) w_state_nxt = ST_DATA;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err_evt   = 1'b1;
                end
            end
            ST_DATA: begin
                if (if_ldr.rx_valid) begin
                    w_data_nxt[{r_idx, 3'b000} +: 8] = if_ldr.rx_data;
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) w_state_nxt = ST_TAIL;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err_evt   = 1'b1;
                end
            end
            ST_TAIL: begin
                if (if_ldr.rx_valid) begin
                    w_state_nxt = ST_IDLE;
                    if (if_ldr.rx_data != END_BYTE) begin
                        w_err_evt = 1'b1;
                    end else if ((w_region <= REG_DMEM_MAX) || (w_region == REG_IMEM)) begin
                        w_state_nxt    = ST_WRITE;
                        w_wr_valid_nxt = 1'b1;
                        w_wr_sel_nxt   = (w_region == REG_IMEM);
                        w_wr_addr_nxt  = r_addr[DEPTH_A-1:0];
                        w_wr_data_nxt  = r_data[WIDTH_D-1:0];
                    end else if (w_region == REG_CTRL) begin
                        if (r_addr[1:0] == CTRL_CPU_RESET) w_cpu_reset_nxt = r_data[0];
                        if (r_addr[1:0] == CTRL_RESUME)    w_resume_nxt    = r_data[0];
                        if (r_addr[1:0] == CTRL_MASTER)    w_master_nxt    = r_data[0];
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err_evt   = 1'b1;
                end
            end
            ST_WRITE: begin
                // Bytes arriving while a write is pending are overruns.
                w_err_evt = if_ldr.rx_valid;
                if (if_ldr.wr_ready) begin
                    w_wr_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_addr      <= 16'd0;
            r_data      <= 32'd0;
            r_wr_valid  <= 1'b0;
            r_wr_sel_i  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cpu_reset <= CPU_RESET_INIT;
            r_resume    <= 1'b0;
            r_master    <= MASTER_INIT;
            r_busy      <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_wr_valid  <= w_wr_valid_nxt;
            r_wr_sel_i  <= w_wr_sel_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_resume    <= w_resume_nxt;
            r_master    <= w_master_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_err_evt) r_err_count <= sat_inc8(r_err_count);
        end
    end

    assign if_ldr.wr_valid = r_wr_valid;
    assign if_ldr.wr_sel_i = r_wr_sel_i;
    assign if_ldr.wr_addr  = r_wr_addr;
    assign if_ldr.wr_data  = r_wr_data;
    assign o_cpu_reset     = r_cpu_reset;
    assign o_resume        = r_resume;
    assign o_master        = r_master;
    assign o_busy          = r_busy;
    assign o_err_count     = r_err_count;
endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed bench for uart_loader_ctrl with hand-computed expectations.
module tb_uart_loader_ctrl;
    logic       clk;
    logic       rst_n;
    logic       cpu_reset, resume, master, busy;
    logic [7:0] err_count;
    int         n_cmp = 0;
    int         n_err = 0;

    uart_loader_ctrl_if #(.WIDTH_D(32), .DEPTH_A(12)) u_if ();

    uart_loader_ctrl #(
        .WIDTH_D(32), .DEPTH_A(12), .TIMEOUT(16),
        .CPU_RESET_INIT(1'b0), .MASTER_INIT(1'b1)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .if_ldr      (u_if),
        .o_cpu_reset (cpu_reset),
        .o_resume    (resume),
        .o_master    (master),
        .o_busy      (busy),
        .o_err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; byte is sampled at the next edge.
    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        tick();
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input logic [7:0] tail);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        send_byte(tail);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_wr_valid"},  32'(u_if.wr_valid), 32'd0);
        check({pfx, "_wr_sel_i"},  32'(u_if.wr_sel_i), 32'd0);
        check({pfx, "_wr_addr"},   32'(u_if.wr_addr),  32'd0);
        check({pfx, "_wr_data"},   u_if.wr_data,       32'd0);
        check({pfx, "_cpu_reset"}, 32'(cpu_reset),     32'd0);
        check({pfx, "_resume"},    32'(resume),        32'd0);
        check({pfx, "_master"},    32'(master),        32'd1);
        check({pfx, "_busy"},      32'(busy),          32'd0);
        check({pfx, "_err"},       32'(err_count),     32'd0);
    endtask

    task automatic do_reset();
        u_if.rx_valid = 1'b0;
        u_if.wr_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_write(input string pfx, input logic sel, input logic [11:0] a, input logic [31:0] d);
        check({pfx, "_valid"}, 32'(u_if.wr_valid), 32'd1);
        check({pfx, "_sel"},   32'(u_if.wr_sel_i), 32'(sel));
        check({pfx, "_addr"},  32'(u_if.wr_addr),  32'(a));
        check({pfx, "_data"},  u_if.wr_data,       d);
    endtask

    initial begin
        rst_n         = 1'b0;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        u_if.wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Instruction RAM write, ready immediately.
        send_frame(32'h0000_4003, 32'h1A08_0040, 8'h55);
        check_write("imem", 1'b1, 12'h003, 32'h1A08_0040);
        check("imem_busy", 32'(busy), 32'd1);
        tick();
        check("imem_valid_drop", 32'(u_if.wr_valid), 32'd0);
        check("imem_idle", 32'(busy), 32'd0);
        check("imem_err", 32'(err_count), 32'd0);

        // Data RAM write stalled 5 cycles, overrun byte injected.
        u_if.wr_ready = 1'b0;
        send_frame(32'h0000_0000, 32'h1234_5678, 8'h55);
        for (int i = 0; i < 6; i++) begin
            check_write($sformatf("stall%0d", i), 1'b0, 12'h000, 32'h1234_5678);
            u_if.rx_data  = 8'h99;
            u_if.rx_valid = (i == 1);
            if (i == 5) u_if.wr_ready = 1'b1;
            tick();
        end
        u_if.rx_valid = 1'b0;
        check("stall_valid_drop", 32'(u_if.wr_valid), 32'd0);
        check("stall_err", 32'(err_count), 32'd1);
        check("stall_idle", 32'(busy), 32'd0);

        // Control registers.
        send_frame(32'h0000_5000, 32'h1, 8'h55);
        check("ctrl_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ctrl0_no_wr", 32'(u_if.wr_valid), 32'd0);
        check("ctrl0_idle", 32'(busy), 32'd0);
        send_frame(32'h0000_5002, 32'h0, 8'h55);
        check("ctrl_master0", 32'(master), 32'd0);
        check("ctrl2_no_wr", 32'(u_if.wr_valid), 32'd0);
        send_frame(32'h0000_5001, 32'h1, 8'h55);
        check("ctrl_resume1", 32'(resume), 32'd1);
        repeat (5) tick();
        check("ctrl_resume_held", 32'(resume), 32'd1);
        send_frame(32'h0000_5001, 32'h0, 8'h55);
        check("ctrl_resume0", 32'(resume), 32'd0);
        send_frame(32'h0000_5003, 32'h1, 8'h55);
        check("ctrl3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ctrl3_master", 32'(master), 32'd0);
        check("ctrl3_resume", 32'(resume), 32'd0);
        check("ctrl3_no_wr", 32'(u_if.wr_valid), 32'd0);
        send_frame(32'hABCD_5002, 32'h1, 8'h55);
        check("ctrl_hi_ignored", 32'(master), 32'd1);
        send_frame(32'h0000_6010, 32'h1, 8'h55);
        check("reg6_no_wr", 32'(u_if.wr_valid), 32'd0);
        check("reg6_no_err", 32'(err_count), 32'd1);
        check("reg6_idle", 32'(busy), 32'd0);

        // Bad tail, then good frame at the top of the data RAM region.
        do_reset();
        send_frame(32'h0000_0010, 32'hDEAD_BEEF, 8'h56);
        check("badtail_no_wr", 32'(u_if.wr_valid), 32'd0);
        check("badtail_err", 32'(err_count), 32'd1);
        check("badtail_idle", 32'(busy), 32'd0);
        send_frame(32'h0000_3FFF, 32'hCAFE_F00D, 8'h55);
        check_write("after_bad", 1'b0, 12'hFFF, 32'hCAFE_F00D);
        tick();
        check("after_bad_drop", 32'(u_if.wr_valid), 32'd0);

        // Gap watchdog: silence of TIMEOUT cycles, then byte exactly at expiry.
        do_reset();
        send_byte(8'hAA);
        send_byte(8'h21);
        send_byte(8'h00);
        send_byte(8'h00);
        check("wd_busy", 32'(busy), 32'd1);
        repeat (15) tick();
        check("wd_before_exp", 32'(busy), 32'd1);
        check("wd_before_err", 32'(err_count), 32'd0);
        tick();
        check("wd_expired", 32'(busy), 32'd0);
        check("wd_err", 32'(err_count), 32'd1);
        send_byte(8'hAA);
        send_byte(8'h21);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (15) tick();
        send_byte(8'h00);
        check("wd_edge_busy", 32'(busy), 32'd1);
        check("wd_edge_err", 32'(err_count), 32'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h55);
        check_write("wd_edge", 1'b0, 12'h021, 32'h0403_0201);
        tick();

        // Async reset in the middle of DATA.
        send_frame(32'h0000_5000, 32'h1, 8'h55);
        send_frame(32'h0000_5002, 32'h0, 8'h55);
        send_frame(32'h0000_5001, 32'h1, 8'h55);
        send_frame(32'h0000_4123, 32'h55AA_55AA, 8'h55);
        tick();
        send_frame(32'h0000_0001, 32'h0, 8'h00);
        check("pre_rst_err", 32'(err_count), 32'd2);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(8'h10);
        send_byte(8'h77);
        send_byte(8'h88);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(32'h0000_0FFE, 32'h0BAD_F00D, 8'h55);
        check_write("post_rst", 1'b0, 12'hFFE, 32'h0BAD_F00D);
        check("post_rst_err", 32'(err_count), 32'd0);
        check("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        tick();
        check("post_rst_drop", 32'(u_if.wr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
